// File: rtl/color_palette_mixer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | color_palette_mixer_if : CPU byte bus into the palette RAM            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface color_palette_mixer_if #(
    parameter int AW = 6
);
    logic          cpu_we;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_rvalid;

    modport master (
        output cpu_we, cpu_rd, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_we, cpu_rd, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/color_palette_mixer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | color_palette_mixer : layer priority, palette lookup, fade, RGB out   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module color_palette_mixer #(
    parameter int LAYERS   = 2,
    parameter int PIX_W    = 4,
    parameter int CH_W     = 3,
    parameter bit INVERT   = 1'b1,
    parameter int FADE_DIV = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pix_ce,
    input  logic [LAYERS*PIX_W-1:0]   pix_idx,
    input  logic                      blank,
    input  logic                      vblank_pulse,
    input  logic                      fade_start,
    input  logic                      fade_dir,
    output logic                      fade_busy,
    output logic [2:0]                bright,
    output logic [3*CH_W-1:0]         rgb_out,
    color_palette_mixer_if.slave      cpu
);
    localparam int ENTRY_W = 3 * CH_W;
    localparam int LW      = $clog2(LAYERS);
    localparam int EA      = LW + PIX_W;
    localparam int DW      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    // ---------------- priority resolution ----------------
    logic [EA-1:0] pix_addr_d;
    always_comb begin
        pix_addr_d = {LW'(LAYERS - 1), {PIX_W{1'b0}}};
        // Walk from the lowest priority upward so the lowest opaque layer wins.
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (pix_idx[i*PIX_W +: PIX_W] != '0)
                pix_addr_d = {LW'(i), pix_idx[i*PIX_W +: PIX_W]};
        end
    end

    // ---------------- CPU side ----------------
    logic [EA-1:0]      cpu_entry;
    logic               cpu_lane;
    logic               commit;
    logic               rd_ok;
    logic [ENTRY_W-1:0] rd_entry;
    logic [7:0]         rdata_d;
    logic [7:0]         latch_q;
    logic [7:0]         rdata_q;
    logic               rvalid_q;

    assign cpu_entry = cpu.cpu_addr[EA:1];
    assign cpu_lane  = cpu.cpu_addr[0];
    assign commit    = cpu.cpu_we & cpu_lane;
    assign rd_ok     = cpu.cpu_rd & ~cpu.cpu_we;

    logic [ENTRY_W-1:0] mem_q [2**EA];
    logic [EA-1:0]      s1_addr_q;
    logic [ENTRY_W-1:0] s2_data_q;

    assign rd_entry = mem_q[cpu_entry];
    assign rdata_d  = cpu_lane ? 8'(rd_entry >> 8) : rd_entry[7:0];

    // Palette storage; the pixel port reads old data on a same-edge commit.
    always_ff @(posedge clk) begin
        if (commit)
            mem_q[cpu_entry] <= {cpu.cpu_wdata[ENTRY_W-9:0], latch_q};
        if (pix_ce)
            s2_data_q <= mem_q[s1_addr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (cpu.cpu_we && !cpu_lane)
                latch_q <= cpu.cpu_wdata;
            rvalid_q <= rd_ok;
            if (rd_ok)
                rdata_q <= rdata_d;
        end
    end

    assign cpu.cpu_rdata  = rdata_q;
    assign cpu.cpu_rvalid = rvalid_q;

    // ---------------- fade FSM ----------------
    state_t        state_q, state_d;
    logic [2:0]    bright_q, bright_d;
    logic [DW-1:0] div_q, div_d;
    logic          dir_q, dir_d;

    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        div_d    = div_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (fade_start && (bright_q != (fade_dir ? 3'd7 : 3'd0))) begin
                    state_d = RUN;
                    dir_d   = fade_dir;
                    div_d   = '0;
                end
            end
            RUN: begin
                if (vblank_pulse) begin
                    if (div_q == DIV_LAST) begin
                        div_d    = '0;
                        bright_d = dir_q ? bright_q + 3'd1 : bright_q - 3'd1;
                        if (bright_d == (dir_q ? 3'd7 : 3'd0))
                            state_d = IDLE;
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bright_q <= 3'd7;
            div_q    <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            div_q    <= div_d;
            dir_q    <= dir_d;
        end
    end

    assign fade_busy = (state_q == RUN);
    assign bright    = bright_q;

    // ---------------- pixel pipeline ----------------
    logic               s1_blank_q;
    logic               s2_blank_q;
    logic [ENTRY_W-1:0] rgb_q;
    logic [ENTRY_W-1:0] scaled;
    logic [ENTRY_W-1:0] rgb_d;
    logic [3:0]         gain;

    assign gain = {1'b0, bright_q} + 4'd1;

    for (genvar k = 0; k < 3; k++) begin : g_ch
        logic [CH_W+3:0] prod;
        assign prod = (CH_W+4)'(s2_data_q[k*CH_W +: CH_W]) * (CH_W+4)'(gain);
        assign scaled[k*CH_W +: CH_W] = prod[CH_W+2:3];
    end

    assign rgb_d = (s2_blank_q ? {ENTRY_W{1'b0}} : scaled) ^ {ENTRY_W{INVERT}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_addr_q  <= '0;
            s1_blank_q <= 1'b1;
            s2_blank_q <= 1'b1;
            rgb_q      <= {ENTRY_W{INVERT}};
        end else if (pix_ce) begin
            s1_addr_q  <= pix_addr_d;
            s1_blank_q <= blank;
            s2_blank_q <= s1_blank_q;
            rgb_q      <= rgb_d;
        end
    end

    assign rgb_out = rgb_q;
endmodule
`default_nettype wire

// File: tb/tb_color_palette_mixer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_color_palette_mixer : directed vectors for color_palette_mixer     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_color_palette_mixer;
    localparam int AW = 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_ce;
    logic [7:0] pix_idx;
    logic       blank;
    logic       vblank_pulse;
    logic       fade_start;
    logic       fade_dir;
    logic       fade_busy;
    logic [2:0] bright;
    logic [8:0] rgb_out;

    int total = 0;
    int bad   = 0;

    color_palette_mixer_if #(.AW(AW)) cpu_bus ();

    color_palette_mixer #(
        .LAYERS(2), .PIX_W(4), .CH_W(3), .INVERT(1'b1), .FADE_DIV(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_ce       (pix_ce),
        .pix_idx      (pix_idx),
        .blank        (blank),
        .vblank_pulse (vblank_pulse),
        .fade_start   (fade_start),
        .fade_dir     (fade_dir),
        .fade_busy    (fade_busy),
        .bright       (bright),
        .rgb_out      (rgb_out),
        .cpu          (cpu_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [AW-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = data;
        @(negedge clk);
        cpu_bus.cpu_we    = 1'b0;
    endtask

    task automatic cpu_rd_chk(input logic [AW-1:0] addr, input logic [7:0] exp, input string tag);
        @(negedge clk);
        cpu_bus.cpu_rd   = 1'b1;
        cpu_bus.cpu_addr = addr;
        @(negedge clk);
        cpu_bus.cpu_rd   = 1'b0;
        chk({tag, "_rvalid"}, 32'(cpu_bus.cpu_rvalid), 32'd1);
        chk({tag, "_rdata"}, 32'(cpu_bus.cpu_rdata), 32'(exp));
    endtask

    task automatic pix_chk(input logic [3:0] l1, input logic [3:0] l0, input logic b,
                           input logic [8:0] exp, input string tag);
        @(negedge clk);
        pix_idx = {l1, l0};
        blank   = b;
        repeat (3) @(negedge clk);
        chk(tag, 32'(rgb_out), 32'(exp));
    endtask

    task automatic vpulse(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vblank_pulse = 1'b1;
            @(negedge clk);
            vblank_pulse = 1'b0;
        end
    endtask

    task automatic fade_go(input logic dir);
        @(negedge clk);
        fade_dir   = dir;
        fade_start = 1'b1;
        @(negedge clk);
        fade_start = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n           = 1'b0;
        pix_ce            = 1'b1;
        pix_idx           = '0;
        blank             = 1'b0;
        vblank_pulse      = 1'b0;
        fade_start        = 1'b0;
        fade_dir          = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_rd    = 1'b0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_rgb",    32'(rgb_out), 32'h1FF);
        chk("rst_rdata",  32'(cpu_bus.cpu_rdata), 32'h0);
        chk("rst_rvalid", 32'(cpu_bus.cpu_rvalid), 32'h0);
        chk("rst_bright", 32'(bright), 32'd7);
        chk("rst_busy",   32'(fade_busy), 32'd0);
        reset_n = 1'b1;

        // Basic lookup: entry 21 = 0x1C7
        cpu_wr(6'd42, 8'hC7);
        cpu_wr(6'd43, 8'h01);
        pix_chk(4'd5, 4'd0, 1'b0, 9'h038, "basic");

        // Pipeline holds while pix_ce is low
        @(negedge clk);
        pix_ce = 1'b0;
        blank  = 1'b1;
        repeat (4) @(negedge clk);
        chk("ce_hold", 32'(rgb_out), 32'h038);
        pix_ce = 1'b1;
        repeat (3) @(negedge clk);
        chk("ce_resume", 32'(rgb_out), 32'h1FF);
        blank = 1'b0;

        // Readback and write/read collision
        cpu_rd_chk(6'd42, 8'hC7, "rd_lo");
        cpu_rd_chk(6'd43, 8'h01, "rd_hi");
        @(negedge clk);
        chk("rvalid_drop", 32'(cpu_bus.cpu_rvalid), 32'd0);
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_rd    = 1'b1;
        cpu_bus.cpu_addr  = 6'd43;
        cpu_bus.cpu_wdata = 8'h00;
        @(negedge clk);
        cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_rd = 1'b0;
        chk("rw_rvalid", 32'(cpu_bus.cpu_rvalid), 32'd0);
        cpu_rd_chk(6'd43, 8'h00, "rw_applied");
        cpu_wr(6'd43, 8'h01);

        // Priority
        cpu_wr(6'd6,  8'hAA);
        cpu_wr(6'd7,  8'h00);
        cpu_wr(6'd32, 8'h00);
        cpu_wr(6'd33, 8'h00);
        pix_chk(4'd5, 4'd3, 1'b0, 9'h155, "prio_l0");
        pix_chk(4'd0, 4'd0, 1'b0, 9'h1FF, "prio_bg");
        pix_chk(4'd5, 4'd0, 1'b1, 9'h1FF, "blank");
        pix_chk(4'd5, 4'd0, 1'b0, 9'h038, "prio_l1");

        // Fade down
        fade_go(1'b0);
        chk("fd_busy", 32'(fade_busy), 32'd1);
        vpulse(3);
        chk("fd_3p", 32'(bright), 32'd7);
        vpulse(1);
        chk("fd_4p", 32'(bright), 32'd6);
        vpulse(12);
        chk("fd_16p", 32'(bright), 32'd3);
        pix_chk(4'd5, 4'd0, 1'b0, 9'h13C, "fade_b3");
        vpulse(12);
        chk("fd_28p", 32'(bright), 32'd0);
        chk("fd_done", 32'(fade_busy), 32'd0);
        fade_go(1'b0);
        chk("fd_at_tgt", 32'(fade_busy), 32'd0);

        // Reset during fade up
        fade_go(1'b1);
        chk("fu_busy", 32'(fade_busy), 32'd1);
        vpulse(4);
        chk("fu_4p", 32'(bright), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rf_bright", 32'(bright), 32'd7);
        chk("rf_busy",   32'(fade_busy), 32'd0);
        chk("rf_rgb",    32'(rgb_out), 32'h1FF);
        @(negedge clk);
        reset_n = 1'b1;

        // Half-written entry abandoned by reset
        cpu_wr(6'd42, 8'hFF);
        reset_pulse();
        cpu_wr(6'd43, 8'h01);
        cpu_rd_chk(6'd42, 8'h00, "lc_lo");
        cpu_rd_chk(6'd43, 8'h01, "lc_hi");
        pix_chk(4'd5, 4'd0, 1'b0, 9'h0FF, "lc_pix");

        // Commit colliding with the S2 read of the same entry
        cpu_wr(6'd42, 8'hC7);
        cpu_wr(6'd43, 8'h01);
        cpu_wr(6'd42, 8'h00);
        pix_chk(4'd0, 4'd3, 1'b0, 9'h155, "coll_pre");
        @(negedge clk);
        pix_idx = {4'd5, 4'd0};
        @(negedge clk);
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = 6'd43;
        cpu_bus.cpu_wdata = 8'h00;
        @(negedge clk);
        cpu_bus.cpu_we = 1'b0;
        @(negedge clk);
        chk("coll_old", 32'(rgb_out), 32'h038);
        @(negedge clk);
        chk("coll_new", 32'(rgb_out), 32'h1FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
